// File: rtl/reg_file_8x16.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_8x16
// Purpose  : Eight-entry, 16-bit register file with a captured N/Z/C status
//            flag register. Sits upstream of the ALU: two combinational read
//            ports feed the ALU operands, one synchronous write port takes
//            the ALU result back, and a separately enabled flag register
//            latches the ALU status outputs for the control sequencer.
// Ports    :
//   clk              in   1   system clock, rising-edge active
//   reset            in   1   asynchronous, active-high clear of all state
//   W_En             in   1   write enable for the register array
//   W_Adr            in   3   write address
//   W_Data           in  16   write data (normally ALU Y)
//   R_Adr, S_Adr     in   3   read addresses for ports R and S
//   Flag_En          in   1   capture enable for the flag register
//   N_in,Z_in,C_in   in   1   ALU status inputs
//   R, S             out 16   contents of the addressed registers
//   N, Z, C          out  1   registered status flags
// Revision : 1.0  initial release
// ============================================================================
module reg_file_8x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_En,
  input  logic [2:0]  W_Adr,
  input  logic [15:0] W_Data,
  input  logic [2:0]  R_Adr,
  input  logic [2:0]  S_Adr,
  input  logic        Flag_En,
  input  logic        N_in,
  input  logic        Z_in,
  input  logic        C_in,
  output logic [15:0] R,
  output logic [15:0] S,
  output logic        N,
  output logic        Z,
  output logic        C
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 16;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic [2:0]       flags_q;
  logic [2:0]       flags_d;

  // One-hot write select: a 3-to-8 decode of the write address, gated by
  // the enable so at most one register loads per edge.
  always_comb begin
    wr_sel = '0;
    if (W_En) begin
      wr_sel[W_Adr] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = wr_sel[i] ? W_Data : regs_q[i];
    end
  end

  // Flags packed as {N, Z, C}.
  always_comb begin
    flags_d = flags_q;
    if (Flag_En) begin
      flags_d = {N_in, Z_in, C_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      flags_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      flags_q <= flags_d;
    end
  end

  // Reads come straight from the stored array; a same-cycle write to the
  // addressed register is not forwarded, so the old value shows until the edge.
  assign R = regs_q[R_Adr];
  assign S = regs_q[S_Adr];

  assign N = flags_q[2];
  assign Z = flags_q[1];
  assign C = flags_q[0];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_8x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_8x16
// Purpose  : Self-checking bench for reg_file_8x16. A behavioural array model
//            is compared with the read ports and flags every falling edge,
//            and directed scenarios add literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_8x16;

  logic        clk;
  logic        reset;
  logic        W_En;
  logic [2:0]  W_Adr;
  logic [15:0] W_Data;
  logic [2:0]  R_Adr;
  logic [2:0]  S_Adr;
  logic        Flag_En;
  logic        N_in, Z_in, C_in;
  logic [15:0] R, S;
  logic        N, Z, C;

  // Stimulus sources; in loop mode the write data and status come from a
  // small ADD-only ALU fed by the read ports.
  logic        loop_mode;
  logic [15:0] wdata_drv;
  logic        n_drv, z_drv, c_drv;
  logic [16:0] alu_sum;

  assign alu_sum = {1'b0, R} + {1'b0, S};
  assign W_Data  = loop_mode ? alu_sum[15:0] : wdata_drv;
  assign N_in    = loop_mode ? alu_sum[15] : n_drv;
  assign Z_in    = loop_mode ? (alu_sum[15:0] == 16'h0000) : z_drv;
  assign C_in    = loop_mode ? alu_sum[16] : c_drv;

  reg_file_8x16 dut (
    .clk    (clk),
    .reset  (reset),
    .W_En   (W_En),
    .W_Adr  (W_Adr),
    .W_Data (W_Data),
    .R_Adr  (R_Adr),
    .S_Adr  (S_Adr),
    .Flag_En(Flag_En),
    .N_in   (N_in),
    .Z_in   (Z_in),
    .C_in   (C_in),
    .R      (R),
    .S      (S),
    .N      (N),
    .Z      (Z),
    .C      (C)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain array of stored words and three flag bits.
  logic [15:0] mdl [8];
  logic        mN, mZ, mC;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mdl[i] <= 16'h0000;
      mN <= 1'b0; mZ <= 1'b0; mC <= 1'b0;
    end else begin
      if (W_En) mdl[W_Adr] <= W_Data;
      if (Flag_En) begin
        mN <= N_in; mZ <= Z_in; mC <= C_in;
      end
    end
  end

  logic run_cmp;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cyc_R", R, mdl[R_Adr]);
      chk("cyc_S", S, mdl[S_Adr]);
      chk("cyc_NZC", {13'd0, N, Z, C}, {13'd0, mN, mZ, mC});
    end
  end

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    W_En = 1'b1; W_Adr = a; wdata_drv = d;
    tick();
    W_En = 1'b0;
  endtask

  initial begin
    run_cmp   = 1'b0;
    loop_mode = 1'b0;
    reset     = 1'b1;
    W_En = 1'b0; W_Adr = '0; wdata_drv = '0;
    R_Adr = '0; S_Adr = '0;
    Flag_En = 1'b0; n_drv = 1'b0; z_drv = 1'b0; c_drv = 1'b0;

    // Power-on reset values, before any clock edge.
    #3;
    chk("por_R", R, 16'h0000);
    chk("por_S", S, 16'h0000);
    chk("por_NZC", {13'd0, N, Z, C}, 16'h0000);

    tick();
    reset   = 1'b0;
    run_cmp = 1'b1;

    // Random contents and flags.
    for (int i = 0; i < 8; i++) begin
      R_Adr = 3'(i); S_Adr = 3'(7 - i);
      wr(3'(i), 16'($urandom));
    end
    Flag_En = 1'b1; n_drv = 1'b1; z_drv = 1'b1; c_drv = 1'b1;
    tick();
    Flag_En = 1'b0;
    chk("flags_set", {13'd0, N, Z, C}, 16'h0007);

    // Asynchronous reset with no clock edge: everything reads zero.
    #3;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      R_Adr = 3'(i); S_Adr = 3'(7 - i);
      #1;
      chk("rst_R", R, 16'h0000);
      chk("rst_S", S, 16'h0000);
    end
    chk("rst_NZC", {13'd0, N, Z, C}, 16'h0000);
    // Writes and flag captures ignored while reset is held.
    W_En = 1'b1; W_Adr = 3'd4; wdata_drv = 16'hDEAD;
    Flag_En = 1'b1;
    tick();
    W_En = 1'b0; Flag_En = 1'b0;
    reset = 1'b0;
    R_Adr = 3'd4; #1;
    chk("rst_hold_wr", R, 16'h0000);
    chk("rst_hold_flag", {13'd0, N, Z, C}, 16'h0000);

    // Write/read-back.
    wr(3'd3, 16'h1234);
    wr(3'd5, 16'h5555);
    R_Adr = 3'd3; S_Adr = 3'd5; #1;
    chk("rb_R3", R, 16'h1234);
    chk("rb_S5", S, 16'h5555);
    R_Adr = 3'd5; #1;
    chk("rb_R5_same", R, 16'h5555);
    chk("rb_S5_same", S, 16'h5555);

    // Enable gating.
    W_En = 1'b0; W_Adr = 3'd3; wdata_drv = 16'hFFFF;
    Flag_En = 1'b0; n_drv = 1'b1;
    repeat (3) tick();
    R_Adr = 3'd3; #1;
    chk("gate_wr", R, 16'h1234);
    chk("gate_flagN", {15'd0, N}, 16'h0000);
    n_drv = 1'b0; z_drv = 1'b0; c_drv = 1'b0;

    // Same-cycle read/write: no bypass.
    wr(3'd2, 16'hAAAA);
    R_Adr = 3'd2; W_Adr = 3'd2; wdata_drv = 16'h5678; W_En = 1'b1;
    #1;
    chk("rw_before", R, 16'hAAAA);
    tick();
    W_En = 1'b0;
    chk("rw_after", R, 16'h5678);

    // Closed loop: reg2 = reg0 + reg1 with flags captured.
    wr(3'd0, 16'hBC45);
    wr(3'd1, 16'h86AB);
    R_Adr = 3'd0; S_Adr = 3'd1; W_Adr = 3'd2;
    loop_mode = 1'b1; W_En = 1'b1; Flag_En = 1'b1;
    tick();
    loop_mode = 1'b0; W_En = 1'b0; Flag_En = 1'b0;
    R_Adr = 3'd2; #1;
    chk("loop_reg2", R, 16'h42F0);
    chk("loop_C", {15'd0, C}, 16'h0001);
    chk("loop_Z", {15'd0, Z}, 16'h0000);
    chk("loop_N", {15'd0, N}, 16'h0000);

    // Reset mid-operation with a write pending.
    W_En = 1'b1; W_Adr = 3'd7; wdata_drv = 16'h9ABC; R_Adr = 3'd7;
    @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    chk("mid_rst_R7", R, 16'h0000);
    chk("mid_rst_NZC", {13'd0, N, Z, C}, 16'h0000);
    @(posedge clk);
    #5;
    reset = 1'b0;
    #1;
    chk("mid_rst_held", R, 16'h0000);
    tick();
    W_En = 1'b0;
    chk("post_rst_wr", R, 16'h9ABC);

    tick();
    tick();
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
